// File: rtl/core_fetch_buffer_pkg.sv
// Shared constants and helpers for the IF->ID fetch buffer.
package core_fetch_buffer_pkg;

  localparam int unsigned FBUF_XLEN  = 32;
  localparam int unsigned FBUF_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

  // Source of an o_Event pulse.
  typedef enum logic [1:0] {
    EV_NONE     = 2'b00,
    EV_OVERFLOW = 2'b01,
    EV_MISALIGN = 2'b10
  } fbuf_event_e;

  // A fetch address is misaligned when it is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of {pc, instr} pairs with flush.
module fetch_fifo
  import core_fetch_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = FBUF_XLEN,
  parameter int unsigned DEPTH = FBUF_DEPTH
) (
  input  logic                       i_Clk,
  input  logic                       i_Rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [XLEN-1:0]            wr_pc,
  input  logic [XLEN-1:0]            wr_instr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_instr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_pop;
  logic            do_push;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the head slot first, so a push while full is legal alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge i_Clk) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]    <= wr_pc;
      instr_mem[wr_ptr] <= wr_instr;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/core_fetch_buffer.sv
// IF->ID boundary: pairs each fetch PC with the word returned one cycle later,
// queues the pair, and presents it to decode under valid/ready.
module core_fetch_buffer
  import core_fetch_buffer_pkg::*;
#(
  parameter int unsigned      XLEN      = FBUF_XLEN,
  parameter int unsigned      DEPTH     = FBUF_DEPTH,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(core_fetch_buffer_pkg::NOP_INSTR)
) (
  input  logic            i_Clk,
  input  logic            i_Rstn,
  input  logic            i_ReadEn,
  input  logic [XLEN-1:0] i_ReadAddr,
  input  logic [XLEN-1:0] i_InstrData,
  input  logic            i_FlushEn,
  input  logic            i_DecReady,
  output logic            o_Valid,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_PC,
  output logic            o_StallReq,
  output logic            o_Event
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic            r_PendEn;
  logic [XLEN-1:0] r_PendPC;
  logic            misalign;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic [AW+1:0]   occupancy;
  fbuf_event_e     ev_cause;

  assign misalign = i_ReadEn & is_misaligned(i_ReadAddr[1:0]);
  assign push     = r_PendEn & ~i_FlushEn;
  assign pop      = o_Valid & i_DecReady;

  // Capture the outstanding request so its data can be paired next cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      r_PendEn <= 1'b0;
      r_PendPC <= '0;
    end else begin
      r_PendEn <= i_ReadEn & ~i_FlushEn & ~misalign;
      r_PendPC <= i_ReadAddr;
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rstn     (i_Rstn),
    .push       (push),
    .pop        (pop),
    .flush      (i_FlushEn),
    .wr_pc      (r_PendPC),
    .wr_instr   (i_InstrData),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  // Classify this cycle's error, if any: dropped push on a full queue, or bad PC.
  always_comb begin
    ev_cause = EV_NONE;
    if (push && full && !pop) ev_cause = EV_OVERFLOW;
    else if (misalign)        ev_cause = EV_MISALIGN;
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) o_Event <= 1'b0;
    else         o_Event <= (ev_cause != EV_NONE);
  end

  // Stall looks only at registered state so decode ready never reaches fetch.
  always_comb begin
    occupancy  = (AW+2)'(count) + (AW+2)'(r_PendEn);
    o_StallReq = occupancy >= (AW+2)'(DEPTH);
  end

  // Head presentation; an empty queue shows a NOP at PC 0.
  always_comb begin
    o_Valid = ~empty;
    o_Instr = empty ? NOP_INSTR : head_instr;
    o_PC    = empty ? '0 : head_pc;
  end

endmodule

// File: tb/tb_core_fetch_buffer.sv
// Self-checking bench for core_fetch_buffer using an expected-entry queue.
module tb_core_fetch_buffer;

  localparam int unsigned DEPTH = 2;

  logic        i_Clk = 1'b0;
  logic        i_Rstn;
  logic        i_ReadEn;
  logic [31:0] i_ReadAddr;
  logic [31:0] i_InstrData;
  logic        i_FlushEn;
  logic        i_DecReady;
  logic        o_Valid;
  logic [31:0] o_Instr;
  logic [31:0] o_PC;
  logic        o_StallReq;
  logic        o_Event;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] sb[$];        // {pc, instr} expected in order
  logic        m_pend    = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic        m_event   = 1'b0;

  always #5 i_Clk = ~i_Clk;

  core_fetch_buffer #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rstn      (i_Rstn),
    .i_ReadEn    (i_ReadEn),
    .i_ReadAddr  (i_ReadAddr),
    .i_InstrData (i_InstrData),
    .i_FlushEn   (i_FlushEn),
    .i_DecReady  (i_DecReady),
    .o_Valid     (o_Valid),
    .o_Instr     (o_Instr),
    .o_PC        (o_PC),
    .o_StallReq  (o_StallReq),
    .o_Event     (o_Event)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory model: 0x100 returns 0x00500093, others a PC-derived word.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0050_0093 ^ ((a ^ 32'h100) << 12);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic cyc(input logic rstn, input logic ren, input logic [31:0] addr,
                     input logic flush, input logic dready, input logic chk);
    logic        exp_valid;
    logic        do_pop;
    logic        mis;
    logic [63:0] head;
    i_Rstn      = rstn;
    i_ReadEn    = ren;
    i_ReadAddr  = addr;
    i_FlushEn   = flush;
    i_DecReady  = dready;
    i_InstrData = instr_of(m_pend_pc);
    #1;
    exp_valid = (sb.size() != 0);
    if (chk) begin
      check("valid", 32'(o_Valid), 32'(exp_valid));
      check("stall", 32'(o_StallReq), 32'((sb.size() + int'(m_pend)) >= DEPTH));
      check("event", 32'(o_Event), 32'(m_event));
      if (exp_valid) begin
        head = sb[0];
        check("pc", o_PC, head[63:32]);
        check("instr", o_Instr, head[31:0]);
      end else begin
        check("pc_empty", o_PC, 32'h0);
        check("instr_nop", o_Instr, 32'h13);
      end
    end
    mis    = ren & (addr[1:0] != 2'b00);
    do_pop = exp_valid & dready;
    if (!rstn) begin
      sb.delete();
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_event   = 1'b0;
    end else begin
      m_event = mis;
      if (flush) begin
        sb.delete();
      end else begin
        if (do_pop) void'(sb.pop_front());
        if (m_pend) begin
          if (sb.size() < DEPTH) sb.push_back({m_pend_pc, instr_of(m_pend_pc)});
          else                   m_event = 1'b1;
        end
      end
      m_pend    = ren & ~flush & ~mis;
      m_pend_pc = addr;
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input logic dready);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, dready, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic dready);
    cyc(1'b1, 1'b1, addr, 1'b0, dready, 1'b1);
  endtask

  initial begin
    i_Rstn = 1'b0; i_ReadEn = 1'b0; i_ReadAddr = '0; i_InstrData = '0;
    i_FlushEn = 1'b0; i_DecReady = 1'b0;
    @(posedge i_Clk); #1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(o_Valid), 32'h0);
    check("rst_instr", o_Instr, 32'h13);
    check("rst_stall", 32'(o_StallReq), 32'h0);

    // 1: single fetch, visible two cycles after request
    rd(32'h100, 1'b0);
    idle(1'b0);
    check("t1_valid", 32'(o_Valid), 32'h1);
    check("t1_pc", o_PC, 32'h100);
    check("t1_instr", o_Instr, 32'h0050_0093);
    idle(1'b1);
    check("t1_drain", 32'(o_Valid), 32'h0);

    // 2: back-pressure, stall rises at count+pend==2
    rd(32'h0, 1'b0);
    rd(32'h4, 1'b0);
    check("t2_stall", 32'(o_StallReq), 32'h1);
    idle(1'b0);
    idle(1'b0);
    check("t2_noevent", 32'(o_Event), 32'h0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // 3: overflow when fetch ignores stall
    rd(32'h0, 1'b0);
    rd(32'h4, 1'b0);
    rd(32'h8, 1'b0);
    idle(1'b0);
    check("t3_event", 32'(o_Event), 32'h1);
    idle(1'b0);
    check("t3_event_clr", 32'(o_Event), 32'h0);
    check("t3_head", o_PC, 32'h0);
    idle(1'b1);
    idle(1'b1);

    // 4: flush with full queue, pending read of 0x8 and same-cycle read
    rd(32'h0, 1'b0);
    rd(32'h4, 1'b0);
    rd(32'h8, 1'b0);
    cyc(1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1);
    check("t4_valid", 32'(o_Valid), 32'h0);
    check("t4_instr", o_Instr, 32'h13);
    check("t4_pc", o_PC, 32'h0);
    idle(1'b0);
    idle(1'b0);

    // 5: push and pop in the same cycle while full
    rd(32'h0, 1'b0);
    rd(32'h4, 1'b0);
    rd(32'h8, 1'b0);
    idle(1'b1);
    check("t5_head4", o_PC, 32'h4);
    check("t5_noevent", 32'(o_Event), 32'h0);
    idle(1'b1);
    check("t5_head8", o_PC, 32'h8);
    idle(1'b1);

    // 6: misaligned fetch, then reset mid-stream
    rd(32'h102, 1'b0);
    check("t6_event", 32'(o_Event), 32'h1);
    idle(1'b0);
    check("t6_empty", 32'(o_Valid), 32'h0);
    rd(32'h10, 1'b0);
    rd(32'h14, 1'b0);
    cyc(1'b0, 1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
    check("t6_rst_valid", 32'(o_Valid), 32'h0);
    check("t6_rst_stall", 32'(o_StallReq), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      cyc(($urandom_range(0, 63) != 0), 1'($urandom()), a,
          ($urandom_range(0, 15) == 0), 1'($urandom()), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
